// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard unit.
//   TW_DEF        : default Tuse/Tnew width
//   REG_ZERO      : architectural $0, never a real destination
//   MULT/DIV_LAT  : default HI/LO occupancy after mult/div enters E
//   FWD_*         : forwarding select encodings (k+1 = slot k)
package hazard_scoreboard_pkg;
    localparam int TW_DEF       = 2;
    localparam int REG_ZERO     = 0;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam int FWD_RF = 0;
    localparam int FWD_E  = 1;
    localparam int FWD_M  = 2;
    localparam int FWD_W  = 3;
endpackage

// File: rtl/hazard_scoreboard_match.sv
// Priority search of one source address over the in-flight destinations.
//   ra_i   : source register address
//   wa_i   : per-slot destination addresses (slot 0 = youngest, E)
//   tnew_i : per-slot remaining Tnew
//   hit_o  : some slot matches
//   slot_o : lowest (youngest) matching slot index
//   tnew_o : remaining Tnew of that slot
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int TW     = TW_DEF,
    parameter int SW     = $clog2(STAGES + 1)
) (
    input  logic [AW-1:0]              ra_i,
    input  logic [STAGES-1:0][AW-1:0]  wa_i,
    input  logic [STAGES-1:0][TW-1:0]  tnew_i,
    output logic                       hit_o,
    output logic [SW-1:0]              slot_o,
    output logic [TW-1:0]              tnew_o
);
    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        tnew_o = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (ra_i != AW'(REG_ZERO) && wa_i[k] == ra_i) begin
                hit_o  = 1'b1;
                slot_o = SW'(k);
                tnew_o = tnew_i[k];
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks in-flight destinations with remaining Tnew
// across STAGES downstream slots plus HI/LO unit occupancy, and produces
// the D-stage stall and per-source forwarding selects.
//   clk, reset        : clock, asynchronous active-high reset
//   d_valid           : D holds a valid instruction
//   d_tuse1/2, d_ra1/2: per-source Tuse and address
//   d_wa, d_tnew      : destination (0 = none) and its Tnew
//   d_mdu_class       : instruction touches HI/LO
//   d_mdu_start/div   : mult/div start, div qualifier
//   stall             : hold F/D, bubble into E
//   fwd_sel1/2        : 0 = register file, k = slot k-1
//   mdu_busy          : HI/LO counter nonzero
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int AW       = 5,
    parameter int TW       = TW_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [TW-1:0] d_tuse1,
    input  logic [TW-1:0] d_tuse2,
    input  logic [AW-1:0] d_ra1,
    input  logic [AW-1:0] d_ra2,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_mdu_class,
    input  logic          d_mdu_start,
    input  logic          d_mdu_div,
    output logic          stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic          mdu_busy
);
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [STAGES-1:0][AW-1:0] wa_q, wa_d;
    logic [STAGES-1:0][TW-1:0] tnew_q, tnew_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      pend_q, pend_d;

    logic          hit1, hit2;
    logic [SW-1:0] slot1, slot2;
    logic [TW-1:0] tn1, tn2;
    logic          stall_data, stall_mdu, issue;

    hazard_match #(.STAGES(STAGES), .AW(AW), .TW(TW), .SW(SW)) u_match1 (
        .ra_i(d_ra1), .wa_i(wa_q), .tnew_i(tnew_q),
        .hit_o(hit1), .slot_o(slot1), .tnew_o(tn1)
    );

    hazard_match #(.STAGES(STAGES), .AW(AW), .TW(TW), .SW(SW)) u_match2 (
        .ra_i(d_ra2), .wa_i(wa_q), .tnew_i(tnew_q),
        .hit_o(hit2), .slot_o(slot2), .tnew_o(tn2)
    );

    assign stall_data = d_valid && ((hit1 && tn1 > d_tuse1) || (hit2 && tn2 > d_tuse2));
    // pend_q covers the cycle where the MDU start sits in E.
    assign stall_mdu  = d_valid && d_mdu_class && (cnt_q != '0 || pend_q);
    assign stall      = stall_data | stall_mdu;
    assign issue      = d_valid && !stall;
    assign mdu_busy   = (cnt_q != '0);

    // A source can only stall on tnew > tuse, so tnew == 0 never coincides
    // with a stall caused by that source.
    assign fwd_sel1 = (hit1 && tn1 == '0) ? slot1 + SW'(1) : SW'(FWD_RF);
    assign fwd_sel2 = (hit2 && tn2 == '0) ? slot2 + SW'(1) : SW'(FWD_RF);

    always_comb begin
        wa_d      = '0;
        tnew_d    = '0;
        wa_d[0]   = issue ? d_wa   : '0;
        tnew_d[0] = issue ? d_tnew : '0;
        for (int k = 1; k < STAGES; k++) begin
            wa_d[k]   = wa_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end
    end

    always_comb begin
        pend_d = issue && d_mdu_start;
        if (issue && d_mdu_start)
            cnt_d = d_mdu_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        else
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wa_q   <= '0;
            tnew_q <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            wa_q   <= wa_d;
            tnew_q <= tnew_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_valid = 1'b0;
    logic [1:0] d_tuse1 = '0, d_tuse2 = '0, d_tnew = '0;
    logic [4:0] d_ra1 = '0, d_ra2 = '0, d_wa = '0;
    logic       d_mdu_class = 1'b0, d_mdu_start = 1'b0, d_mdu_div = 1'b0;
    logic       stall, mdu_busy;
    logic [1:0] fwd_sel1, fwd_sel2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_tuse1(d_tuse1), .d_tuse2(d_tuse2), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_wa(d_wa), .d_tnew(d_tnew), .d_mdu_class(d_mdu_class),
        .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .mdu_busy(mdu_busy)
    );

    // Model: history of what entered E on each of the last 3 edges, each
    // with its Tnew as issued; being k edges old means Tnew has aged by k.
    // HI/LO busy is an absolute edge deadline.
    typedef struct { int wa; int tnew; bit mdu; } ent_t;
    ent_t hist[3];
    int   ncyc = 0;
    int   mdu_end = 0;

    task automatic m_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 1'b0};
        mdu_end = ncyc;
    endtask

    task automatic m_eval(output bit st, output int f1, output int f2, output bit bz);
        int k1, k2, e1, e2;
        bit sd, sm;
        k1 = -1; k2 = -1; e1 = 0; e2 = 0;
        for (int k = 0; k < 3; k++) begin
            if (k1 < 0 && d_ra1 != 0 && hist[k].wa == int'(d_ra1)) k1 = k;
            if (k2 < 0 && d_ra2 != 0 && hist[k].wa == int'(d_ra2)) k2 = k;
        end
        if (k1 >= 0) e1 = (hist[k1].tnew > k1) ? hist[k1].tnew - k1 : 0;
        if (k2 >= 0) e2 = (hist[k2].tnew > k2) ? hist[k2].tnew - k2 : 0;
        sd = d_valid && ((k1 >= 0 && e1 > int'(d_tuse1)) || (k2 >= 0 && e2 > int'(d_tuse2)));
        bz = (ncyc < mdu_end);
        sm = d_valid && d_mdu_class && (bz || hist[0].mdu);
        st = sd || sm;
        f1 = (k1 >= 0 && e1 == 0) ? k1 + 1 : 0;
        f2 = (k2 >= 0 && e2 == 0) ? k2 + 1 : 0;
    endtask

    task automatic m_update();
        bit st, bz; int f1, f2; bit iss;
        m_eval(st, f1, f2, bz);
        iss = d_valid && !st;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = iss ? '{int'(d_wa), int'(d_tnew), d_mdu_start} : '{0, 0, 1'b0};
        ncyc++;
        if (iss && d_mdu_start) mdu_end = ncyc + (d_mdu_div ? 10 : 5);
    endtask

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One cycle: compare DUT against model, clock, advance model.
    task automatic cyc();
        bit st, bz; int f1, f2;
        m_eval(st, f1, f2, bz);
        tests++;
        if (stall !== st || int'(fwd_sel1) != f1 || int'(fwd_sel2) != f2 || mdu_busy !== bz) begin
            fails++;
            $display("FAIL model t=%0t: stall %b/%b fwd1 %0d/%0d fwd2 %0d/%0d busy %b/%b (got/expected)",
                     $time, stall, st, fwd_sel1, f1, fwd_sel2, f2, mdu_busy, bz);
        end
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic drv(bit v, int ra1, int tu1, int ra2, int tu2, int wa, int tn,
                       bit cls, bit st, bit dv);
        d_valid = v; d_ra1 = 5'(ra1); d_tuse1 = 2'(tu1); d_ra2 = 5'(ra2); d_tuse2 = 2'(tu2);
        d_wa = 5'(wa); d_tnew = 2'(tn); d_mdu_class = cls; d_mdu_start = st; d_mdu_div = dv;
        #1;
    endtask

    task automatic idle(int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    // Count stall cycles with inputs held, bounded.
    task automatic count_stall(output int n);
        n = 0;
        while (stall && n < 16) begin
            n++;
            cyc();
            #1;
        end
    endtask

    initial begin
        int n;
        m_reset();
        // Reset state, with a reader presented
        drv(1, 8, 0, 9, 0, 0, 0, 1, 0, 0);
        #1;
        chk("reset stall", stall, 0);
        chk("reset fwd1", fwd_sel1, 0);
        chk("reset fwd2", fwd_sel2, 0);
        chk("reset busy", mdu_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Load-use: lw $8 (tnew 3) then addu reading $8 (tuse 1)
        drv(1, 29, 1, 0, 0, 8, 3, 0, 0, 0);
        chk("lw issue stall", stall, 0);
        cyc();
        drv(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
        chk("loaduse stall0", stall, 1);
        count_stall(n);
        chk("loaduse stall cycles", n, 2);
        chk("loaduse release", stall, 0);
        cyc();
        idle(3);

        // ALU chain: addu $9 (tnew 2), sw with rt=$9 (tuse2 2)
        drv(1, 0, 0, 0, 0, 9, 2, 0, 0, 0);
        cyc();
        drv(1, 29, 1, 9, 2, 0, 0, 0, 0, 0);
        chk("chain stall", stall, 0);
        chk("chain fwd2", fwd_sel2, 0);
        cyc();
        // now in slot 1 with tnew 1: a tuse-0 reader stalls once, then takes W
        drv(1, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        chk("chain slot1 stall", stall, 1);
        cyc();
        #1;
        chk("chain slot2 stall", stall, 0);
        chk("chain slot2 fwd2", fwd_sel2, 3);
        cyc();
        idle(3);

        // Youngest wins: ori $5, lui $5, beq reading $5 (tuse 0)
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        cyc();
        drv(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("youngest stall", stall, 1);
        chk("youngest fwd1 during stall", fwd_sel1, 0);
        cyc();
        #1;
        chk("youngest release", stall, 0);
        chk("youngest fwd1", fwd_sel1, 2);
        cyc();
        idle(3);

        // $0 guard
        drv(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        chk("zero stall", stall, 0);
        chk("zero fwd1", fwd_sel1, 0);
        cyc();
        idle(3);

        // div then mflo
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("div issue stall", stall, 0);
        chk("div issue busy", mdu_busy, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        chk("mflo busy", mdu_busy, 1);
        count_stall(n);
        chk("div stall cycles", n, 10);
        chk("div done busy", mdu_busy, 0);
        cyc();
        idle(2);

        // mult then mfhi
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        count_stall(n);
        chk("mult stall cycles", n, 5);
        cyc();
        idle(2);

        // d_valid=0 never stalls even with HI/LO busy
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("invalid no stall", stall, 0);
        chk("invalid busy", mdu_busy, 1);
        cyc();
        // counter now 9: two more edges to 7, landing addu $3 (tnew 2) on the last
        cyc();
        drv(1, 0, 0, 0, 0, 3, 2, 0, 0, 0);
        chk("addu3 stall", stall, 0);
        cyc();
        drv(1, 3, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("prereset stall", stall, 1);
        chk("prereset busy", mdu_busy, 1);
        reset = 1'b1;
        #1;
        chk("midreset stall", stall, 0);
        chk("midreset fwd1", fwd_sel1, 0);
        chk("midreset busy", mdu_busy, 0);
        m_reset();
        reset = 1'b0;
        #1;
        chk("postreset stall", stall, 0);
        chk("postreset fwd1", fwd_sel1, 0);
        cyc();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
